// File: rtl/cond_pkg.sv
// Shared types and constants for the board input conditioner.
package cond_pkg;
  typedef enum logic {S_IDLE, S_COUNT} db_state_t;

  localparam int DEBOUNCE_CYCLES_SIM = 4;
  // stop, debug and step lanes that sit above the slide switches
  localparam int N_CTRL_LANES = 3;
endpackage

// File: rtl/debounce_cell.sv
// One input lane: 2-FF synchroniser followed by a counting debounce FSM
// that only moves the registered level after DEBOUNCE_CYCLES stable samples.
module debounce_cell
  import cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_board,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            s1_q, s2_q;
  db_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (s2_q != level_q) begin
          state_d = S_COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      S_COUNT: begin
        // Any reversal abandons the count; the next change starts again from 1.
        if (s2_q == level_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          level_d = s2_q;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
endmodule

// File: rtl/input_conditioner.sv
// Conditions raw board buttons/switches: every lane is synchronised and
// debounced independently, and the step button also yields a 1-cycle pulse.
module input_conditioner
  import cond_pkg::*;
#(
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk_board,
  input  logic            rst_n,
  input  logic            stop_raw,
  input  logic            debug_raw,
  input  logic            step_raw,
  input  logic [N_SW-1:0] sw_raw,
  output logic            stop,
  output logic            Debug_DM,
  output logic [N_SW-1:0] switch_in,
  output logic            step_pulse
);
  localparam int N_LANES   = N_SW + N_CTRL_LANES;
  localparam int STOP_IDX  = N_SW;
  localparam int DEBUG_IDX = N_SW + 1;
  localparam int STEP_IDX  = N_SW + 2;

  logic [N_LANES-1:0] raw_vec;
  logic [N_LANES-1:0] lvl_vec;

  assign raw_vec = {step_raw, debug_raw, stop_raw, sw_raw};

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
        .clk_board(clk_board),
        .rst_n    (rst_n),
        .raw      (raw_vec[gi]),
        .level    (lvl_vec[gi])
      );
    end
  endgenerate

  logic step_lvl;
  logic step_lvl_q, step_lvl_d;
  logic step_pulse_q, step_pulse_d;

  assign step_lvl = lvl_vec[STEP_IDX];

  always_comb begin
    step_lvl_d   = step_lvl;
    step_pulse_d = step_lvl & ~step_lvl_q;
  end

  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) begin
      step_lvl_q   <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      step_lvl_q   <= step_lvl_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign stop       = lvl_vec[STOP_IDX];
  assign Debug_DM   = lvl_vec[DEBUG_IDX];
  assign switch_in  = lvl_vec[N_SW-1:0];
  assign step_pulse = step_pulse_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce period.
module tb_input_conditioner;
  localparam int N_SW = 10;

  logic            clk_board = 1'b0;
  logic            rst_n;
  logic            stop_raw, debug_raw, step_raw;
  logic [N_SW-1:0] sw_raw;
  logic            stop, Debug_DM, step_pulse;
  logic [N_SW-1:0] switch_in;

  int total = 0;
  int bad   = 0;

  input_conditioner #(
    .N_SW           (N_SW),
    .DEBOUNCE_CYCLES(cond_pkg::DEBOUNCE_CYCLES_SIM)
  ) dut (
    .clk_board (clk_board),
    .rst_n     (rst_n),
    .stop_raw  (stop_raw),
    .debug_raw (debug_raw),
    .step_raw  (step_raw),
    .sw_raw    (sw_raw),
    .stop      (stop),
    .Debug_DM  (Debug_DM),
    .switch_in (switch_in),
    .step_pulse(step_pulse)
  );

  always #5 clk_board = ~clk_board;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("chk %s: got=%0h ok", tag, got);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk_board);
    #1;
  endtask

  task automatic check_all_levels(input string tag, input logic s, input logic d,
                                  input logic [N_SW-1:0] sw);
    check({tag, ".stop"}, 32'(stop), 32'(s));
    check({tag, ".dbg"},  32'(Debug_DM), 32'(d));
    check({tag, ".sw"},   32'(switch_in), 32'(sw));
  endtask

  int n_pulse, p1_at, p3_at, wide;
  logic prev_pulse;

  initial begin
    // 1: reset with all raws high, then release
    rst_n = 1'b0; stop_raw = 1'b1; debug_raw = 1'b1; step_raw = 1'b1; sw_raw = '1;
    repeat (3) tick();
    check_all_levels("t1_rst", 1'b0, 1'b0, '0);
    check("t1_rst.pulse", 32'(step_pulse), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_all_levels($sformatf("t1_e%0d", i), 1'b0, 1'b0, '0);
      check($sformatf("t1_e%0d.pulse", i), 32'(step_pulse), 32'd0);
    end
    tick();
    check_all_levels("t1_e6", 1'b1, 1'b1, '1);
    check("t1_e6.pulse", 32'(step_pulse), 32'd0);
    tick();
    check("t1_e7.pulse", 32'(step_pulse), 32'd1);
    tick();
    check("t1_e8.pulse", 32'(step_pulse), 32'd0);
    repeat (3) tick();
    check("t1_e11.pulse", 32'(step_pulse), 32'd0);

    // bring every lane back to 0
    stop_raw = 1'b0; debug_raw = 1'b0; step_raw = 1'b0; sw_raw = '0;
    repeat (12) tick();
    check_all_levels("idle", 1'b0, 1'b0, '0);

    // 2: single switch lane
    sw_raw = 10'b00_0000_1000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("t2_e%0d.sw", i), 32'(switch_in), 32'd0);
    end
    tick();
    check("t2_e6.sw", 32'(switch_in), 32'h008);

    // 3: stop bounces 1,0,1,0 then holds 1
    stop_raw = 1'b1; tick(); check("t3_b1", 32'(stop), 32'd0);
    stop_raw = 1'b0; tick(); check("t3_b2", 32'(stop), 32'd0);
    stop_raw = 1'b1; tick(); check("t3_b3", 32'(stop), 32'd0);
    stop_raw = 1'b0; tick(); check("t3_b4", 32'(stop), 32'd0);
    stop_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("t3_e%0d", i), 32'(stop), 32'd0);
    end
    tick();
    check("t3_e6", 32'(stop), 32'd1);

    // 4: 3-cycle glitch on debug_raw never reaches Debug_DM
    debug_raw = 1'b1;
    repeat (3) tick();
    debug_raw = 1'b0;
    check("t4_g0", 32'(Debug_DM), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("t4_g%0d", i), 32'(Debug_DM), 32'd0);
    end

    // 5: step held 50, released 20, pressed again
    n_pulse = 0; p1_at = 0; p3_at = 0; wide = 0; prev_pulse = 1'b0;
    step_raw = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (step_pulse) begin
        n_pulse++;
        if (n_pulse == 1) p1_at = i;
        if (prev_pulse) wide++;
      end
      prev_pulse = step_pulse;
    end
    step_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step_pulse) n_pulse++;
      if (step_pulse && prev_pulse) wide++;
      prev_pulse = step_pulse;
    end
    step_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step_pulse) begin
        n_pulse++;
        p3_at = i;
        if (prev_pulse) wide++;
      end
      prev_pulse = step_pulse;
    end
    check("t5_count", 32'(n_pulse), 32'd2);
    check("t5_first_at", 32'(p1_at), 32'd7);
    check("t5_second_at", 32'(p3_at), 32'd7);
    check("t5_wide", 32'(wide), 32'd0);
    step_raw = 1'b0;

    // 6: async reset mid-count on stop
    stop_raw = 1'b0;
    repeat (12) tick();
    check("t6_pre", 32'(stop), 32'd0);
    check("t6_pre.sw", 32'(switch_in), 32'h008);
    stop_raw = 1'b1;
    repeat (4) tick();   // stop lane now holds cnt=2
    #2 rst_n = 1'b0;
    #1;
    check("t6_async.stop", 32'(stop), 32'd0);
    check("t6_async.sw", 32'(switch_in), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("t6_e%0d", i), 32'(stop), 32'd0);
    end
    tick();
    check("t6_e6", 32'(stop), 32'd1);
    check("t6_e6.sw", 32'(switch_in), 32'h008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
